// File: rtl/stream_frame_buffer.sv
// Purpose : elastic byte FIFO (2**AW entries) between an AXI-stream byte source and
//           the compressor input, emitting one {length, CRC-32} descriptor per frame.
// Latency : a byte pushed into an empty buffer is presented on o_t* two cycles later.
// Backpressure: i_tready drops when the buffer holds 2**AW bytes. A pop in that cycle
//               does not reopen i_tready. o_t* is held stable while o_tready=0.
//
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   i_tvalid/i_tready/i_tdata/i_tlast   input byte stream
//   o_tvalid/o_tready/o_tdata/o_tlast   output byte stream, first-word-fall-through
//   f_valid/f_len/f_crc           one-cycle descriptor pulse; f_len and f_crc hold until the next one
//   level                         bytes held in the block, including the output register
//
// Optional feature: define STREAM_FRAME_CRC32_EN to compute the CRC-32 (IEEE, reflected).
// When it is not defined, f_crc reads 0.

module stream_frame_buffer #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    output logic          i_tready,
    input  logic          i_tvalid,
    input  logic [7:0]    i_tdata,
    input  logic          i_tlast,
    input  logic          o_tready,
    output logic          o_tvalid,
    output logic [7:0]    o_tdata,
    output logic          o_tlast,
    output logic          f_valid,
    output logic [31:0]   f_len,
    output logic [31:0]   f_crc,
    output logic [AW:0]   level
);

    localparam logic [AW:0] DEPTH_L = {1'b1, {AW{1'b0}}};

    logic [8:0]    mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          ram_empty;
    logic          load;

    // Readiness comes only from the registered level, so a pop at full does not
    // allow a push in the same cycle.
    assign i_tready  = !rst && (level < DEPTH_L);
    assign push      = i_tvalid & i_tready;
    assign pop       = o_tvalid & o_tready;

    // The RAM can never fill completely. Whenever it holds data, the output
    // register is either occupied or refilled on the same edge. So equal
    // pointers always mean the RAM is empty. For the same reason, a read never
    // targets the address being written in that cycle.
    assign ram_empty = (wr_ptr == rd_ptr);

    // The synchronous read port lands directly in the output register. The
    // read is issued whenever the output register is free or being popped.
    // This prefetches the next word without a separate staging register and
    // keeps the empty-to-valid latency at two cycles.
    assign load      = !ram_empty && (!o_tvalid || o_tready);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {i_tlast, i_tdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
            o_tlast  <= 1'b0;
            level    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                {o_tlast, o_tdata} <= mem[rd_ptr];
                rd_ptr             <= rd_ptr + 1'b1;
                o_tvalid           <= 1'b1;
            end else if (pop) begin
                o_tvalid <= 1'b0;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Frame length, saturating at all-ones.
    logic [31:0] cnt;
    logic [31:0] cnt_inc;

    assign cnt_inc = (&cnt) ? cnt : cnt + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            f_valid <= 1'b0;
            f_len   <= '0;
        end else begin
            f_valid <= push & i_tlast;
            if (push) begin
                if (i_tlast) begin
                    f_len <= cnt_inc;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
            end
        end
    end

`ifdef STREAM_FRAME_CRC32_EN
    logic [31:0] crc;
    logic [31:0] crc_nxt;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int b = 0; b < 8; b++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    assign crc_nxt = crc32_byte(crc, i_tdata);

    always_ff @(posedge clk) begin
        if (rst) begin
            crc   <= 32'hFFFF_FFFF;
            f_crc <= '0;
        end else if (push) begin
            if (i_tlast) begin
                f_crc <= ~crc_nxt;
                crc   <= 32'hFFFF_FFFF;
            end else begin
                crc <= crc_nxt;
            end
        end
    end
`else
    assign f_crc = '0;
`endif

endmodule

// File: tb/tb_stream_frame_buffer.sv
// Purpose : directed and randomized checks of stream_frame_buffer (AW=10).
// Latency : checks the two-cycle empty-to-valid path and zero-bubble streaming.
// Backpressure: exercises the full condition, output stalls and random ready patterns.

module tb_stream_frame_buffer;

    localparam int DEPTH = 1024;
    localparam int NRAND = 20000;

    logic        clk;
    logic        rst;
    logic        i_tready;
    logic        i_tvalid;
    logic [7:0]  i_tdata;
    logic        i_tlast;
    logic        o_tready;
    logic        o_tvalid;
    logic [7:0]  o_tdata;
    logic        o_tlast;
    logic        f_valid;
    logic [31:0] f_len;
    logic [31:0] f_crc;
    logic [10:0] level;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int max_level = 0;
    int stall_err = 0;
    logic       stall_prev = 1'b0;
    logic [8:0] stall_dat = '0;

    logic [8:0]  out_q[$];
    int          pop_cyc_q[$];
    logic [31:0] len_q[$];
    logic [31:0] crc_q[$];

    stream_frame_buffer dut (
        .clk      (clk),
        .rst      (rst),
        .i_tready (i_tready),
        .i_tvalid (i_tvalid),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .o_tready (o_tready),
        .o_tvalid (o_tvalid),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .f_valid  (f_valid),
        .f_len    (f_len),
        .f_crc    (f_crc),
        .level    (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observer. It runs on the falling edge, where inputs and outputs are
    // stable for the coming rising edge.
    always @(negedge clk) begin
        if (o_tvalid && o_tready) begin
            out_q.push_back({o_tlast, o_tdata});
            pop_cyc_q.push_back(cyc);
        end
        if (f_valid) begin
            len_q.push_back(f_len);
            crc_q.push_back(f_crc);
        end
        if (int'(level) > max_level) max_level = int'(level);
        if (stall_prev && (!o_tvalid || ({o_tlast, o_tdata} != stall_dat))) stall_err++;
        stall_prev = o_tvalid && !o_tready && !rst;
        stall_dat  = {o_tlast, o_tdata};
    end

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] crc_exp(input logic [31:0] v);
`ifdef STREAM_FRAME_CRC32_EN
        return v;
`else
        return 32'd0;
`endif
    endfunction

    task automatic clear_obs();
        out_q.delete();
        pop_cyc_q.delete();
        len_q.delete();
        crc_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; i_tvalid = 1'b0; i_tdata = '0; i_tlast = 1'b0; o_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vec_cnt++;
        if (i_tready !== 1'b0) begin
            err_cnt++; $display("FAIL reset_tready_in_rst got=%b exp=0", i_tready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        vec_cnt++;
        if ({i_tready, o_tvalid, o_tdata, o_tlast, f_valid, level} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 11'd0}) begin
            err_cnt++;
            $display("FAIL reset_state got rdy=%b vld=%b dat=%h last=%b fv=%b lvl=%0d exp 1/0/00/0/0/0",
                     i_tready, o_tvalid, o_tdata, o_tlast, f_valid, level);
        end
        vec_cnt++;
        if ({f_len, f_crc} !== 64'd0) begin
            err_cnt++; $display("FAIL reset_desc got len=%h crc=%h exp 0/0", f_len, f_crc);
        end
    endtask

    task automatic test_single_byte();
        clear_obs();
        @(posedge clk); #1;
        o_tready = 1'b1; i_tvalid = 1'b1; i_tdata = 8'h00; i_tlast = 1'b1;
        @(posedge clk); #1;
        i_tvalid = 1'b0; i_tlast = 1'b0;
        vec_cnt++;
        if ({o_tvalid, level} !== {1'b0, 11'd1}) begin
            err_cnt++; $display("FAIL single_n1 got vld=%b lvl=%0d exp 0/1", o_tvalid, level);
        end
        vec_cnt++;
        if ({f_valid, f_len, f_crc} !== {1'b1, 32'd1, crc_exp(32'hD202_EF8D)}) begin
            err_cnt++;
            $display("FAIL single_desc got fv=%b len=%0d crc=%h exp 1/1/%h", f_valid, f_len, f_crc, crc_exp(32'hD202_EF8D));
        end
        @(posedge clk); #1;
        vec_cnt++;
        if ({o_tvalid, o_tdata, o_tlast, f_valid, f_len} !== {1'b1, 8'h00, 1'b1, 1'b0, 32'd1}) begin
            err_cnt++;
            $display("FAIL single_n2 got vld=%b dat=%h last=%b fv=%b len=%0d exp 1/00/1/0/1", o_tvalid, o_tdata, o_tlast, f_valid, f_len);
        end
        @(posedge clk); #1;
        vec_cnt++;
        if ({o_tvalid, level} !== {1'b0, 11'd0}) begin
            err_cnt++; $display("FAIL single_drained got vld=%b lvl=%0d exp 0/0", o_tvalid, level);
        end
    endtask

    task automatic test_crc_vector();
        logic [7:0] msg [9];
        int bad;
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        clear_obs();
        o_tready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            i_tvalid = 1'b1; i_tdata = msg[i]; i_tlast = (i == 8);
        end
        @(posedge clk); #1;
        i_tvalid = 1'b0; i_tlast = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        vec_cnt++;
        if (out_q.size() != 9) begin
            err_cnt++; $display("FAIL crc_vec_count got=%0d exp=9", out_q.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 9; i++) if (out_q[i] !== {(i == 8), msg[i]}) bad++;
            vec_cnt++;
            if (bad != 0) begin
                err_cnt++; $display("FAIL crc_vec_data got %0d wrong bytes exp 0", bad);
            end
            vec_cnt++;
            if (pop_cyc_q[8] - pop_cyc_q[0] != 8) begin
                err_cnt++; $display("FAIL crc_vec_bubbles got span=%0d exp=8", pop_cyc_q[8] - pop_cyc_q[0]);
            end
        end
        vec_cnt++;
        if (len_q.size() != 1 || len_q[0] !== 32'd9 || crc_q[0] !== crc_exp(32'hCBF4_3926)) begin
            err_cnt++;
            $display("FAIL crc_vec_desc got n=%0d len=%0d crc=%h exp 1/9/%h", len_q.size(),
                     (len_q.size() > 0) ? len_q[0] : 32'd0, (crc_q.size() > 0) ? crc_q[0] : 32'd0, crc_exp(32'hCBF4_3926));
        end
    endtask

    task automatic test_full();
        int bad;
        int waited;
        clear_obs();
        o_tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk); #1;
            i_tvalid = 1'b1; i_tdata = 8'(i) ^ 8'h5A; i_tlast = ((i % 256) == 255);
        end
        @(posedge clk); #1;
        i_tvalid = 1'b0; i_tlast = 1'b0;
        vec_cnt++;
        if ({i_tready, level} !== {1'b0, 11'd1024}) begin
            err_cnt++; $display("FAIL full_level got rdy=%b lvl=%0d exp 0/1024", i_tready, level);
        end
        vec_cnt++;
        if ({o_tvalid, o_tdata, o_tlast} !== {1'b1, 8'h5A, 1'b0}) begin
            err_cnt++; $display("FAIL full_head got vld=%b dat=%h last=%b exp 1/5a/0", o_tvalid, o_tdata, o_tlast);
        end
        i_tvalid = 1'b1; i_tdata = 8'hEE; o_tready = 1'b1;
        @(posedge clk); #1;
        i_tvalid = 1'b0;
        vec_cnt++;
        if ({i_tready, level, o_tdata} !== {1'b1, 11'd1023, 8'h5B}) begin
            err_cnt++; $display("FAIL full_pushpop got rdy=%b lvl=%0d dat=%h exp 1/1023/5b", i_tready, level, o_tdata);
        end
        waited = 0;
        while (out_q.size() < DEPTH && waited < 2000) begin
            @(posedge clk); #1; waited++;
        end
        repeat (4) @(posedge clk);
        #1;
        vec_cnt++;
        if (out_q.size() != DEPTH) begin
            err_cnt++; $display("FAIL full_drain_count got=%0d exp=%0d", out_q.size(), DEPTH);
        end else begin
            bad = 0;
            for (int i = 0; i < DEPTH; i++) if (out_q[i] !== {((i % 256) == 255), 8'(i) ^ 8'h5A}) bad++;
            vec_cnt++;
            if (bad != 0) begin
                err_cnt++; $display("FAIL full_drain_order got %0d wrong bytes exp 0", bad);
            end
        end
        vec_cnt++;
        if ({i_tready, level, o_tvalid} !== {1'b1, 11'd0, 1'b0}) begin
            err_cnt++; $display("FAIL full_after got rdy=%b lvl=%0d vld=%b exp 1/0/0", i_tready, level, o_tvalid);
        end
        vec_cnt++;
        if (len_q.size() != 4 || len_q[0] !== 32'd256 || len_q[3] !== 32'd256) begin
            err_cnt++; $display("FAIL full_desc got n=%0d exp 4 descriptors of 256", len_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  b [4];
        logic [31:0] c1;
        logic [31:0] c2;
        int bad;
        b  = '{8'hA1, 8'hA2, 8'hA3, 8'hB1};
        c1 = ~crc_step(crc_step(crc_step(32'hFFFF_FFFF, b[0]), b[1]), b[2]);
        c2 = ~crc_step(32'hFFFF_FFFF, b[3]);
        clear_obs();
        o_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 3) begin
                vec_cnt++;
                if ({f_valid, f_len} !== {1'b1, 32'd3}) begin
                    err_cnt++; $display("FAIL b2b_first_pulse got fv=%b len=%0d exp 1/3", f_valid, f_len);
                end
            end
            i_tvalid = 1'b1; i_tdata = b[i]; i_tlast = (i >= 2);
        end
        @(posedge clk); #1;
        i_tvalid = 1'b0; i_tlast = 1'b0;
        vec_cnt++;
        if ({f_valid, f_len, f_crc} !== {1'b1, 32'd1, crc_exp(c2)}) begin
            err_cnt++; $display("FAIL b2b_second_pulse got fv=%b len=%0d crc=%h exp 1/1/%h", f_valid, f_len, f_crc, crc_exp(c2));
        end
        repeat (6) @(posedge clk);
        #1;
        vec_cnt++;
        if (len_q.size() != 2 || len_q[0] !== 32'd3 || len_q[1] !== 32'd1 || crc_q[0] !== crc_exp(c1)) begin
            err_cnt++; $display("FAIL b2b_desc got n=%0d exp 2 descriptors len 3,1", len_q.size());
        end
        bad = (out_q.size() != 4) ? 1 : 0;
        if (bad == 0) for (int i = 0; i < 4; i++) if (out_q[i] !== {(i >= 2), b[i]}) bad++;
        vec_cnt++;
        if (bad != 0) begin
            err_cnt++; $display("FAIL b2b_output got n=%0d with %0d bad exp 4 bytes, tlast on 3 and 4", out_q.size(), bad);
        end
    endtask

    task automatic test_random();
        logic [8:0]  exp_q[$];
        logic [31:0] crc;
        logic [7:0]  bv;
        logic        acc;
        int sent;
        int c0;
        int bad;
        int waited;
        clear_obs();
        max_level = 0; stall_err = 0; sent = 0; crc = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        i_tvalid = 1'b0;
        c0 = cyc;
        while (sent < NRAND && (cyc - c0) < 80000) begin
            o_tready = ($urandom_range(0, 3) != 0);
            if (!i_tvalid && $urandom_range(0, 3) != 0) begin
                bv = 8'($urandom);
                i_tvalid = 1'b1; i_tdata = bv; i_tlast = (sent == NRAND - 1);
                exp_q.push_back({i_tlast, bv});
                crc = crc_step(crc, bv);
            end
            @(negedge clk);
            acc = i_tvalid && i_tready;
            @(posedge clk); #1;
            if (acc) begin
                sent++; i_tvalid = 1'b0; i_tlast = 1'b0;
            end
        end
        i_tvalid = 1'b0; i_tlast = 1'b0; o_tready = 1'b1;
        vec_cnt++;
        if (sent != NRAND) begin
            err_cnt++; $display("FAIL rand_timeout got sent=%0d exp=%0d", sent, NRAND);
        end
        waited = 0;
        while (out_q.size() < exp_q.size() && waited < 3000) begin
            @(posedge clk); #1; waited++;
        end
        repeat (4) @(posedge clk);
        #1;
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) if (out_q[i] !== exp_q[i]) bad++;
        vec_cnt++;
        if (out_q.size() != exp_q.size() || bad != 0) begin
            err_cnt++; $display("FAIL rand_data got n=%0d bad=%0d exp n=%0d bad=0", out_q.size(), bad, exp_q.size());
        end
        vec_cnt++;
        if (max_level > DEPTH) begin
            err_cnt++; $display("FAIL rand_level got max=%0d exp <=%0d", max_level, DEPTH);
        end
        vec_cnt++;
        if (stall_err != 0) begin
            err_cnt++; $display("FAIL rand_stall_hold got %0d violations exp 0", stall_err);
        end
        vec_cnt++;
        if (len_q.size() != 1 || len_q[0] !== 32'(NRAND) || crc_q[0] !== crc_exp(~crc)) begin
            err_cnt++; $display("FAIL rand_desc got n=%0d exp 1 descriptor len=%0d", len_q.size(), NRAND);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] c;
        clear_obs();
        o_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            i_tvalid = 1'b1; i_tdata = 8'h10 + 8'(i); i_tlast = 1'b0;
        end
        @(posedge clk); #1;
        i_tvalid = 1'b0;
        vec_cnt++;
        if (level !== 11'd5) begin
            err_cnt++; $display("FAIL midrst_pre_level got=%0d exp=5", level);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        vec_cnt++;
        if (i_tready !== 1'b0) begin
            err_cnt++; $display("FAIL midrst_tready got=%b exp=0", i_tready);
        end
        rst = 1'b0;
        vec_cnt++;
        if ({level, o_tvalid, o_tdata} !== {11'd0, 1'b0, 8'h00}) begin
            err_cnt++; $display("FAIL midrst_state got lvl=%0d vld=%b dat=%h exp 0/0/00", level, o_tvalid, o_tdata);
        end
        repeat (3) @(posedge clk);
        #1;
        vec_cnt++;
        if (len_q.size() != 0) begin
            err_cnt++; $display("FAIL midrst_no_desc got=%0d descriptors exp=0", len_q.size());
        end
        c = ~crc_step(crc_step(32'hFFFF_FFFF, 8'h31), 8'h32);
        o_tready = 1'b1;
        i_tvalid = 1'b1; i_tdata = 8'h31; i_tlast = 1'b0;
        @(posedge clk); #1;
        i_tdata = 8'h32; i_tlast = 1'b1;
        @(posedge clk); #1;
        i_tvalid = 1'b0; i_tlast = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        vec_cnt++;
        if (len_q.size() != 1 || len_q[0] !== 32'd2 || crc_q[0] !== crc_exp(c)) begin
            err_cnt++; $display("FAIL midrst_desc got n=%0d exp 1 descriptor len=2 crc=%h", len_q.size(), crc_exp(c));
        end
        vec_cnt++;
        if (out_q.size() != 2 || out_q[0] !== 9'h031 || out_q[1] !== 9'h132) begin
            err_cnt++; $display("FAIL midrst_output got n=%0d exp 2 bytes 31,32(last)", out_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_crc_vector();
        test_full();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
